// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: controller states, default
// widths and the elaboration-time width check.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } mac_state_e;

    localparam int DEF_LEN_DATA_IN  = 8;
    localparam int DEF_LEN_WEIGHT   = 8;
    localparam int DEF_LEN_DATA_OUT = 18;
    localparam int DEF_LEN_CNT      = 8;

    // The accumulator must hold at least one full signed product.
    function automatic bit widths_ok(input int len_data_in, input int len_weight,
                                     input int len_data_out);
        return len_data_out >= (len_data_in + len_weight);
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Job, operand-stream and result-handshake signals of the MAC sequencer.
// The feeder/consumer side uses the master modport, the controller the slave.
interface mac_seq_ctrl_if #(
    parameter int LEN_DATA_IN  = 8,
    parameter int LEN_WEIGHT   = 8,
    parameter int LEN_DATA_OUT = 18,
    parameter int LEN_CNT      = 8
);
    logic                           START;
    logic [LEN_CNT-1:0]             VEC_LEN;
    logic                           BUSY;
    logic                           IN_VALID;
    logic                           IN_READY;
    logic signed [LEN_DATA_IN-1:0]  DATA_IN;
    logic signed [LEN_WEIGHT-1:0]   WEIGHT_INPUT;
    logic signed [LEN_DATA_OUT-1:0] RESULT;
    logic                           RESULT_VALID;
    logic                           RESULT_READY;
    logic                           OVERFLOW;

    modport master (
        output START, VEC_LEN, IN_VALID, DATA_IN, WEIGHT_INPUT, RESULT_READY,
        input  BUSY, IN_READY, RESULT, RESULT_VALID, OVERFLOW
    );

    modport slave (
        input  START, VEC_LEN, IN_VALID, DATA_IN, WEIGHT_INPUT, RESULT_READY,
        output BUSY, IN_READY, RESULT, RESULT_VALID, OVERFLOW
    );
endinterface

// File: rtl/mac_accum.sv
// Gated signed multiply-accumulate: clears on clr, adds one full product per
// enabled cycle, wraps modulo 2^LEN_DATA_OUT and keeps a sticky overflow flag.
module mac_accum
    import mac_pkg::*;
#(
    parameter int LEN_DATA_IN  = DEF_LEN_DATA_IN,
    parameter int LEN_WEIGHT   = DEF_LEN_WEIGHT,
    parameter int LEN_DATA_OUT = DEF_LEN_DATA_OUT
) (
    input  logic                           clk,
    input  logic                           srst,
    input  logic                           clr,
    input  logic                           en,
    input  logic signed [LEN_DATA_IN-1:0]  data_i,
    input  logic signed [LEN_WEIGHT-1:0]   weight_i,
    output logic signed [LEN_DATA_OUT-1:0] acc_o,
    output logic                           ovf_o
);
    localparam int LEN_PROD = LEN_DATA_IN + LEN_WEIGHT;

    logic signed [LEN_PROD-1:0]     prod;
    logic signed [LEN_DATA_OUT-1:0] prod_ext;
    logic signed [LEN_DATA_OUT-1:0] acc_q, acc_d;
    logic                           ovf_q, add_ovf;

    // Full-precision product, sign-extended sum and per-add overflow detect.
    always_comb begin
        prod     = LEN_PROD'(data_i) * LEN_PROD'(weight_i);
        prod_ext = LEN_DATA_OUT'(prod);
        acc_d    = acc_q + prod_ext;
        // Two same-sign addends giving a result of the other sign overflowed.
        add_ovf  = (acc_q[LEN_DATA_OUT-1] == prod_ext[LEN_DATA_OUT-1]) &&
                   (acc_d[LEN_DATA_OUT-1] != acc_q[LEN_DATA_OUT-1]);
    end

    // Accumulator and sticky flag only move on enabled beats.
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | add_ovf;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer around the gated MAC: accepts VEC_LEN operand pairs,
// then holds the dot product on a valid/ready result handshake.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int LEN_DATA_IN  = DEF_LEN_DATA_IN,
    parameter int LEN_WEIGHT   = DEF_LEN_WEIGHT,
    parameter int LEN_DATA_OUT = DEF_LEN_DATA_OUT,
    parameter int LEN_CNT      = DEF_LEN_CNT
) (
    input  logic          CLK,
    input  logic          SYNC_RST,
    mac_seq_ctrl_if.slave bus
);
    generate
        if (!widths_ok(LEN_DATA_IN, LEN_WEIGHT, LEN_DATA_OUT)) begin : g_width_err
            $error("mac_seq_ctrl: LEN_DATA_OUT must be >= LEN_DATA_IN + LEN_WEIGHT");
        end
    endgenerate

    mac_state_e         state_q;
    logic [LEN_CNT-1:0] cnt_q;
    logic [LEN_CNT-1:0] len_q;
    logic               in_ready_q;
    logic               result_valid_q;
    logic               busy_q;

    logic               beat;
    logic               last_beat;
    logic               acc_clr;

    // in_ready_q is high exactly in ACC, so a beat needs no state decode.
    assign beat      = bus.IN_VALID && in_ready_q;
    assign last_beat = beat && (cnt_q == (len_q - LEN_CNT'(1)));
    // Every accepted START (including zero-length jobs) starts from zero.
    assign acc_clr   = (state_q == IDLE) && bus.START;

    // Controller FSM with registered handshake outputs.
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            len_q          <= '0;
            in_ready_q     <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.START) begin
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (bus.VEC_LEN == '0) begin
                            state_q        <= HOLD;
                            result_valid_q <= 1'b1;
                        end else begin
                            len_q      <= bus.VEC_LEN;
                            state_q    <= ACC;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (beat) begin
                        cnt_q <= cnt_q + LEN_CNT'(1);
                        if (last_beat) begin
                            state_q        <= HOLD;
                            in_ready_q     <= 1'b0;
                            result_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.RESULT_READY) begin
                        state_q        <= IDLE;
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    in_ready_q     <= 1'b0;
                    result_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

    mac_accum #(
        .LEN_DATA_IN (LEN_DATA_IN),
        .LEN_WEIGHT  (LEN_WEIGHT),
        .LEN_DATA_OUT(LEN_DATA_OUT)
    ) u_accum (
        .clk     (CLK),
        .srst    (SYNC_RST),
        .clr     (acc_clr),
        .en      (beat),
        .data_i  (bus.DATA_IN),
        .weight_i(bus.WEIGHT_INPUT),
        .acc_o   (bus.RESULT),
        .ovf_o   (bus.OVERFLOW)
    );

    assign bus.IN_READY     = in_ready_q;
    assign bus.RESULT_VALID = result_valid_q;
    assign bus.BUSY         = busy_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a job-level reference model and a
// per-cycle compare process, plus literal expectations per job.
module tb_mac_seq_ctrl;
    localparam int LDI = 8;
    localparam int LW  = 8;
    localparam int LDO = 16;
    localparam int LC  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.LEN_DATA_IN(LDI), .LEN_WEIGHT(LW),
                      .LEN_DATA_OUT(LDO), .LEN_CNT(LC)) bus ();

    mac_seq_ctrl #(.LEN_DATA_IN(LDI), .LEN_WEIGHT(LW),
                   .LEN_DATA_OUT(LDO), .LEN_CNT(LC)) dut (
        .CLK     (clk),
        .SYNC_RST(rst),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (job level) ----------------
    // m_mode: 0 = waiting for a job, 1 = collecting operands, 2 = result offered
    int     m_mode = 0;
    int     m_left = 0;
    longint m_res  = 0;
    bit     m_ovf  = 1'b0;
    bit     m_just_rst = 1'b0;

    function automatic longint wrap16(input longint s);
        logic signed [LDO-1:0] t;
        t = s[LDO-1:0];
        return longint'(t);
    endfunction

    always @(posedge clk) begin
        longint p, s;
        m_just_rst = 1'b0;
        if (rst) begin
            m_mode = 0; m_left = 0; m_res = 0; m_ovf = 1'b0; m_just_rst = 1'b1;
        end else if (m_mode == 0) begin
            if (bus.START) begin
                m_res = 0;
                m_ovf = 1'b0;
                m_left = int'(bus.VEC_LEN);
                m_mode = (m_left == 0) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (bus.IN_VALID) begin
                p = longint'($signed(bus.DATA_IN)) * longint'($signed(bus.WEIGHT_INPUT));
                s = m_res + p;
                if (s > 32767 || s < -32768) m_ovf = 1'b1;
                m_res = wrap16(s);
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
        end else begin
            if (bus.RESULT_READY) m_mode = 0;
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy",     longint'(bus.BUSY),         longint'(m_mode != 0));
            check("cyc_in_ready", longint'(bus.IN_READY),     longint'(m_mode == 1));
            check("cyc_valid",    longint'(bus.RESULT_VALID), longint'(m_mode == 2));
            if (m_mode == 2 || m_just_rst) begin
                check("cyc_result",   longint'($signed(bus.RESULT)), m_res);
                check("cyc_overflow", longint'(bus.OVERFLOW),        longint'(m_ovf));
            end
        end
    end

    // ---------------- stimulus ----------------
    int jd[8];
    int jw[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input string nm, input int n, input bit stall, input int hold_lo,
                           input bit poke, input longint exp_res, input bit exp_ovf);
        logic pre_valid;
        bus.RESULT_READY = (hold_lo == 0);
        bus.START   = 1'b1;
        bus.VEC_LEN = LC'(n);
        tick();
        bus.START   = 1'b0;
        bus.VEC_LEN = 8'hAA;
        pre_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (stall) begin
                bus.IN_VALID = 1'b0;
                bus.DATA_IN = 8'sd77; bus.WEIGHT_INPUT = 8'sd99;
                tick();
            end
            bus.IN_VALID     = 1'b1;
            bus.DATA_IN      = LDI'(jd[i]);
            bus.WEIGHT_INPUT = LW'(jw[i]);
            if (poke && i == 1) begin
                bus.START = 1'b1; bus.VEC_LEN = 8'd0;
            end
            pre_valid = bus.RESULT_VALID;
            tick();
            bus.START = 1'b0;
        end
        bus.IN_VALID = 1'b0;
        bus.DATA_IN = 8'sd33; bus.WEIGHT_INPUT = 8'sd33;
        check({nm, "_valid_early"}, longint'(pre_valid), 0);
        check({nm, "_valid"},       longint'(bus.RESULT_VALID), 1);
        check({nm, "_in_ready"},    longint'(bus.IN_READY), 0);
        check({nm, "_result"},      longint'($signed(bus.RESULT)), exp_res);
        check({nm, "_overflow"},    longint'(bus.OVERFLOW), longint'(exp_ovf));
        for (int k = 0; k < hold_lo; k++) begin
            bus.START = (poke && k == 2);
            tick();
            bus.START = 1'b0;
            check({nm, "_hold_valid"},  longint'(bus.RESULT_VALID), 1);
            check({nm, "_hold_result"}, longint'($signed(bus.RESULT)), exp_res);
            check({nm, "_hold_busy"},   longint'(bus.BUSY), 1);
        end
        bus.RESULT_READY = 1'b1;
        tick();
        check({nm, "_done_valid"}, longint'(bus.RESULT_VALID), 0);
        check({nm, "_done_busy"},  longint'(bus.BUSY), 0);
        bus.RESULT_READY = 1'b0;
        $display("job %s len=%0d result=%0d overflow=%0b", nm, n,
                 $signed(bus.RESULT), bus.OVERFLOW);
    endtask

    initial begin
        bus.START = 1'b0; bus.VEC_LEN = '0; bus.IN_VALID = 1'b0;
        bus.DATA_IN = '0; bus.WEIGHT_INPUT = '0; bus.RESULT_READY = 1'b0;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_busy",  longint'(bus.BUSY), 0);
        check("rst_valid", longint'(bus.RESULT_VALID), 0);
        check("rst_ready", longint'(bus.IN_READY), 0);
        check("rst_result", longint'($signed(bus.RESULT)), 0);
        rst = 1'b0;
        tick();

        // Basic dot product: -375 + 100 - 8
        jd[0] = -125; jw[0] = 3; jd[1] = 10; jw[1] = 10; jd[2] = 2; jw[2] = -4;
        run_job("basic", 3, 1'b0, 0, 1'b0, -283, 1'b0);
        // Same job with a bubble before every beat
        run_job("stall", 3, 1'b1, 0, 1'b0, -283, 1'b0);
        // Zero-length job
        run_job("zero", 0, 1'b0, 0, 1'b0, 0, 1'b0);
        // 3 x 16129 = 48387 wraps to -17149
        jd[0] = 127; jw[0] = 127; jd[1] = 127; jw[1] = 127; jd[2] = 127; jw[2] = 127;
        run_job("ovf", 3, 1'b0, 0, 1'b0, -17149, 1'b1);
        jd[0] = 1; jw[0] = 1;
        run_job("after_ovf", 1, 1'b0, 0, 1'b0, 1, 1'b0);
        // 16384 - 35 - 16256 with backpressure and stray STARTs
        jd[0] = -128; jw[0] = -128; jd[1] = 5; jw[1] = -7; jd[2] = -128; jw[2] = 127;
        run_job("backpr", 3, 1'b0, 5, 1'b1, 93, 1'b0);

        // Mid-job reset after 2 of 5 beats
        bus.START = 1'b1; bus.VEC_LEN = 8'd5;
        tick();
        bus.START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.IN_VALID = 1'b1; bus.DATA_IN = 8'sd100; bus.WEIGHT_INPUT = 8'sd100;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.IN_VALID = 1'b0;
        check("midrst_busy",     longint'(bus.BUSY), 0);
        check("midrst_in_ready", longint'(bus.IN_READY), 0);
        check("midrst_valid",    longint'(bus.RESULT_VALID), 0);
        check("midrst_result",   longint'($signed(bus.RESULT)), 0);
        check("midrst_overflow", longint'(bus.OVERFLOW), 0);
        $display("job midrst aborted after 2 beats");
        tick();
        jd[0] = -2; jw[0] = 7;
        run_job("post_rst", 1, 1'b0, 0, 1'b0, -14, 1'b0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the signed multiply-accumulate datapath. It accepts a job of VEC_LEN (data, weight) operand pairs over a valid/ready stream and clears the accumulator at job start. It accumulates one product per accepted beat and presents the final dot product on a held result handshake. It sits between the operand feeder (buffer/DMA side) and the downstream consumer, and turns the free-running MAC into a bounded, restartable dot-product engine.

## Interface
Parameters:
- LEN_DATA_IN, 8, signed operand width of DATA_IN
- LEN_WEIGHT, 8, signed operand width of WEIGHT_INPUT
- LEN_DATA_OUT, 18, accumulator/result width; must be ≥ LEN_DATA_IN+LEN_WEIGHT (elaboration error otherwise)
- LEN_CNT, 8, width of VEC_LEN and beat counter

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock, all state on rising edge
- SYNC_RST  in  1  synchronous active-high reset
- START  in  1  job request, sampled only in IDLE
- VEC_LEN  in  LEN_CNT  number of operand pairs, sampled with START
- BUSY  out  1  high in every state except IDLE
- IN_VALID  in  1  operand pair valid
- IN_READY  out  1  controller accepts operand pair
- DATA_IN  in  LEN_DATA_IN  signed data operand
- WEIGHT_INPUT  in  LEN_WEIGHT  signed weight operand
- RESULT  out  LEN_DATA_OUT  signed dot product, valid while RESULT_VALID
- RESULT_VALID  out  1  result available
- RESULT_READY  in  1  consumer takes result
- OVERFLOW  out  1  sticky per job; valid with RESULT

## Operation
- States: IDLE, ACC, HOLD.
- IDLE: IN_READY=0, RESULT_VALID=0. START=1 with VEC_LEN≠0 → latch VEC_LEN, clear accumulator, clear OVERFLOW and beat counter → ACC. START=1 with VEC_LEN=0 → RESULT=0, OVERFLOW=0 → HOLD.
- ACC: IN_READY=1. Beat = IN_VALID&&IN_READY. Each beat: acc ← acc + DATA_IN*WEIGHT_INPUT (full signed product, sign-extended to LEN_DATA_OUT), counter++. Beat with counter==len-1 → HOLD. No beat → hold all state.
- HOLD: IN_READY=0, RESULT_VALID=1, RESULT and OVERFLOW stable. RESULT_READY=1 → IDLE.
- Arithmetic: sum wraps modulo 2^LEN_DATA_OUT, two's complement. OVERFLOW is set when any single add overflows (both operands same sign, result sign differs). It stays set even if a later add brings the true sum back into range.
- START outside IDLE is ignored (no queueing). VEC_LEN changes outside the START sample are ignored.
- SYNC_RST has priority over everything: state IDLE; RESULT, RESULT_VALID, IN_READY, BUSY and OVERFLOW all 0; accumulator and counter 0. A mid-job reset discards the job, with no partial result.

## Timing
- START at edge t → ACC from t+1; first beat can be accepted at edge t+1.
- Throughput 1 beat/cycle. Last beat at edge t → RESULT_VALID=1 and final RESULT from t+1 (1-cycle latency).
- VEC_LEN=0: RESULT_VALID=1 from the cycle after START.
- Result handshake at edge t → IDLE at t+1. A new START is accepted at t+1 at the earliest; minimum job length is N+2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from IN_VALID/RESULT_READY to any output.

## Structure
- Shared package mac_pkg: state enum (IDLE/ACC/HOLD), default width constants, and the width-check function.
- One sub-module: mac_accum (CLR, EN, operands → registered accumulator + sticky overflow). It contains the datapath that was previously free-running, now gated. mac_seq_ctrl holds the FSM, counter and handshakes.

## Test plan
- Basic: VEC_LEN=3, pairs (-125,3),(10,10),(2,-4), IN_VALID continuous, RESULT_READY=1 → RESULT=-283, OVERFLOW=0, RESULT_VALID for 1 cycle exactly 4 cycles after START.
- Stalls: same job with IN_VALID low on alternate cycles → RESULT=-283; the accumulator is unchanged on non-beat cycles.
- Zero length: START with VEC_LEN=0 → RESULT=0, RESULT_VALID the next cycle, IN_READY never 1.
- Overflow: LEN_DATA_OUT=16, VEC_LEN=3, three pairs (127,127) → RESULT=-17149 (wrapped 48387), OVERFLOW=1. The next job, (1,1) with VEC_LEN=1, gives RESULT=1 and OVERFLOW=0.
- Backpressure/ignored START: RESULT_READY low for 5 cycles → RESULT/RESULT_VALID stable. A START pulse during ACC and during HOLD has no effect; BUSY drops 1 cycle after the handshake.
- Reset mid-job: SYNC_RST after 2 of 5 beats → all outputs 0 the next cycle. A following VEC_LEN=1 job with (−2,7) gives RESULT=-14.
